// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bubble encoding and FSM states.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    ST_RUN,
    ST_DROP
  } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage signal bundle: control from hazard/execute, imem request/response, IF/ID outputs.
interface fetch_if;

  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_ren;
  logic [31:0] o_imem_raddr;
  logic        i_imem_valid;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;

  modport master (
    input  i_stall, i_redirect, i_redirect_pc, i_imem_valid, i_imem_rdata,
    output o_imem_ren, o_imem_raddr, o_valid, o_instr, o_pc, o_pc_plus4
  );

  modport slave (
    output i_stall, i_redirect, i_redirect_pc, i_imem_valid, i_imem_rdata,
    input  o_imem_ren, o_imem_raddr, o_valid, o_instr, o_pc, o_pc_plus4
  );

endinterface

// File: rtl/fetch_skid.sv
// One-entry {instr, pc} holding buffer for a response that lands while decode is stalled.
module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc_d    = load_pc;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, skid buffer and IF/ID register.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = DEFAULT_NOP_INSTR
) (
  input logic      i_clk,
  input logic      i_rst,
  fetch_if.master  bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         outstanding_q, outstanding_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic [31:0]  id_pc4_q, id_pc4_d;

  logic         skid_valid, skid_load, skid_drain, skid_clear;
  logic [31:0]  skid_instr, skid_pc;
  logic         skid_empty_next, ren, resp;

  fetch_skid u_skid (
    .clk        (i_clk),
    .rst        (i_rst),
    .load       (skid_load),
    .drain      (skid_drain),
    .clear      (skid_clear),
    .load_instr (bus.i_imem_rdata),
    .load_pc    (req_pc_q),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  always_comb begin
    skid_empty_next = !skid_valid && !(bus.i_stall && bus.i_imem_valid);
    ren  = (state_q == ST_RUN) && !bus.i_redirect
           && (!outstanding_q || bus.i_imem_valid) && skid_empty_next;
    resp = (state_q == ST_RUN) && outstanding_q && bus.i_imem_valid;

    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    valid_d       = valid_q;
    instr_d       = instr_q;
    id_pc_d       = id_pc_q;
    id_pc4_d      = id_pc4_q;
    skid_load     = 1'b0;
    skid_drain    = 1'b0;
    skid_clear    = 1'b0;

    if (ren) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + 32'd4;
    end

    if (bus.i_redirect) begin
      pc_d = bus.i_redirect_pc;
      if (state_q == ST_RUN) begin
        valid_d    = 1'b0;
        instr_d    = NOP_INSTR;
        skid_clear = 1'b1;
        // A response still in flight belongs to the old path; remember to swallow it.
        if (outstanding_q && !bus.i_imem_valid) state_d = ST_DROP;
        else                                    outstanding_d = 1'b0;
      end else if (bus.i_imem_valid) begin
        outstanding_d = 1'b0;
        state_d       = ST_RUN;
      end
    end else if (state_q == ST_DROP) begin
      if (bus.i_imem_valid) begin
        outstanding_d = 1'b0;
        state_d       = ST_RUN;
      end
    end else begin
      if (ren)       outstanding_d = 1'b1;
      else if (resp) outstanding_d = 1'b0;

      if (bus.i_stall) begin
        skid_load = resp;
      end else if (resp) begin
        valid_d  = 1'b1;
        instr_d  = bus.i_imem_rdata;
        id_pc_d  = req_pc_q;
        id_pc4_d = req_pc_q + 32'd4;
      end else if (skid_valid) begin
        valid_d    = 1'b1;
        instr_d    = skid_instr;
        id_pc_d    = skid_pc;
        id_pc4_d   = skid_pc + 32'd4;
        skid_drain = 1'b1;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_ADDR;
      req_pc_q      <= RESET_ADDR;
      outstanding_q <= 1'b0;
      valid_q       <= 1'b0;
      instr_q       <= NOP_INSTR;
      id_pc_q       <= '0;
      id_pc4_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      valid_q       <= valid_d;
      instr_q       <= instr_d;
      id_pc_q       <= id_pc_d;
      id_pc4_q      <= id_pc4_d;
    end
  end

  assign bus.o_imem_ren   = ren;
  assign bus.o_imem_raddr = {pc_q[31:2], 2'b00};
  assign bus.o_valid      = valid_q;
  assign bus.o_instr      = instr_q;
  assign bus.o_pc         = id_pc_q;
  assign bus.o_pc_plus4   = id_pc4_q;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: memory model with variable latency plus an in-order PC-stream reference.
module tb_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'h1357_9BDC;

  logic clk = 1'b0;
  logic rst, rst1;
  always #5 clk = ~clk;

  fetch_if f0 ();
  fetch_if f1 ();

  fetch #(.RESET_ADDR(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut0 (
    .i_clk(clk), .i_rst(rst), .bus(f0.master));
  fetch #(.RESET_ADDR(32'h0000_0080)) dut1 (
    .i_clk(clk), .i_rst(rst1), .bus(f1.master));

  int checks = 0;
  int failures = 0;

  // memory model state
  bit          pend;
  logic [31:0] pend_addr;
  int          cnt;
  int          lat;

  // reference model state
  logic [31:0] exp_pc;
  logic        pv;
  logic [31:0] pi, ppc, ppc4;
  int          valid_seen;
  logic        c_ren;
  logic [31:0] c_raddr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ KEY;
  endfunction

  task automatic model_reset();
    exp_pc = 32'h0;
    pv = 1'b0; pi = NOP; ppc = '0; ppc4 = '0;
  endtask

  task automatic begin_cycle();
    f0.i_imem_valid = 1'b0;
    f0.i_imem_rdata = $urandom;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        f0.i_imem_valid = 1'b1;
        f0.i_imem_rdata = instr_of(pend_addr);
        pend = 1'b0;
      end
    end
  endtask

  task automatic end_cycle(input logic s, input logic r, input logic [31:0] rpc);
    f0.i_stall = s; f0.i_redirect = r; f0.i_redirect_pc = rpc;
    #1;
    c_ren = f0.o_imem_ren; c_raddr = f0.o_imem_raddr;
    if (!rst) begin
      checks++;
      if ((c_ren && pend) !== 1'b0) begin
        failures++; $display("FAIL ren_while_outstanding: got ren=%b pend=%b want no overlap", c_ren, pend);
      end
      if (r) begin
        checks++;
        if (c_ren !== 1'b0) begin failures++; $display("FAIL ren_on_redirect: got %b want 0", c_ren); end
      end
      if (c_ren) begin
        checks++;
        if (c_raddr[1:0] !== 2'b00) begin failures++; $display("FAIL raddr_align: got %h", c_raddr); end
        pend = 1'b1; pend_addr = c_raddr; cnt = lat;
      end
    end
    @(posedge clk); #1;
    if (rst) begin
      model_reset();
    end else begin
      if (r) begin
        checks++;
        if (f0.o_valid !== 1'b0) begin failures++; $display("FAIL redirect_bubble: got %b want 0", f0.o_valid); end
        exp_pc = rpc;
      end else if (s) begin
        checks++;
        if ({f0.o_valid, f0.o_instr, f0.o_pc, f0.o_pc_plus4} !== {pv, pi, ppc, ppc4}) begin
          failures++;
          $display("FAIL stall_hold: got %b %h %h %h want %b %h %h %h", f0.o_valid, f0.o_instr,
                   f0.o_pc, f0.o_pc_plus4, pv, pi, ppc, ppc4);
        end
      end else if (f0.o_valid) begin
        checks++;
        if (f0.o_pc !== exp_pc) begin failures++; $display("FAIL pc_seq: got %h want %h", f0.o_pc, exp_pc); end
        checks++;
        if (f0.o_instr !== instr_of(exp_pc)) begin
          failures++; $display("FAIL instr: got %h want %h", f0.o_instr, instr_of(exp_pc));
        end
        checks++;
        if (f0.o_pc_plus4 !== exp_pc + 32'd4) begin
          failures++; $display("FAIL pc_plus4: got %h want %h", f0.o_pc_plus4, exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
        valid_seen++;
      end
      if (!f0.o_valid) begin
        checks++;
        if (f0.o_instr !== NOP) begin failures++; $display("FAIL bubble_nop: got %h want %h", f0.o_instr, NOP); end
        checks++;
        if ({f0.o_pc, f0.o_pc_plus4} !== {ppc, ppc4}) begin
          failures++; $display("FAIL bubble_pc_hold: got %h %h want %h %h", f0.o_pc, f0.o_pc_plus4, ppc, ppc4);
        end
      end
      pv = f0.o_valid; pi = f0.o_instr; ppc = f0.o_pc; ppc4 = f0.o_pc_plus4;
    end
    @(negedge clk);
  endtask

  task automatic cyc(input logic s, input logic r, input logic [31:0] rpc);
    begin_cycle();
    end_cycle(s, r, rpc);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({f0.o_valid, f0.o_instr, f0.o_pc, f0.o_pc_plus4} !== {1'b0, NOP, 32'h0, 32'h0}) begin
      failures++; $display("FAIL reset_state: got %b %h %h %h want 0 %h 0 0", f0.o_valid, f0.o_instr,
                           f0.o_pc, f0.o_pc_plus4, NOP);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    lat = 1;
    cyc(1'b0, 1'b0, '0);
    checks++;
    if ({c_ren, c_raddr} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL first_ren: got %b %h want 1 00000000", c_ren, c_raddr);
    end
  endtask

  task automatic test_back_to_back();
    for (int unsigned i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, '0);
      checks++;
      if ({f0.o_valid, f0.o_pc, c_ren} !== {1'b1, 32'(i * 4), 1'b1}) begin
        failures++; $display("FAIL back_to_back: got v=%b pc=%h ren=%b want 1 %h 1", f0.o_valid, f0.o_pc, c_ren, 32'(i * 4));
      end
    end
  endtask

  task automatic test_stall();
    bit seen = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, '0);
      checks++;
      if ({f0.o_valid, f0.o_pc, c_ren} !== {1'b1, 32'h4, 1'b0}) begin
        failures++; $display("FAIL stall_skid: got v=%b pc=%h ren=%b want 1 4 0", f0.o_valid, f0.o_pc, c_ren);
      end
    end
    cyc(1'b0, 1'b0, '0);
    checks++;
    if ({f0.o_valid, f0.o_pc} !== {1'b1, 32'h8}) begin
      failures++; $display("FAIL skid_drain: got v=%b pc=%h want 1 8", f0.o_valid, f0.o_pc);
    end
    for (int unsigned i = 0; i < 4 && !seen; i++) begin
      cyc(1'b0, 1'b0, '0);
      seen = f0.o_valid;
    end
    checks++;
    if ({seen, f0.o_pc} !== {1'b1, 32'hC}) begin
      failures++; $display("FAIL after_skid: got seen=%b pc=%h want 1 c", seen, f0.o_pc);
    end
  endtask

  task automatic test_redirect_wait();
    int unsigned n = 0;
    bit found = 1'b0;
    lat = 3;
    for (int unsigned i = 0; i < 6 && !found; i++) begin
      cyc(1'b0, 1'b0, '0);
      found = c_ren;
    end
    lat = 1;
    cyc(1'b0, 1'b1, 32'h100);
    found = 1'b0;
    while (!found && n < 10) begin
      cyc(1'b0, 1'b0, '0);
      n++;
      found = c_ren;
    end
    checks++;
    if ({found, c_raddr, n} !== {1'b1, 32'h100, 32'd3}) begin
      failures++; $display("FAIL redirect_drop: got ren=%b addr=%h after %0d want 1 100 after 3", found, c_raddr, n);
    end
    found = 1'b0;
    for (int unsigned i = 0; i < 4 && !found; i++) begin
      cyc(1'b0, 1'b0, '0);
      found = f0.o_valid;
    end
    checks++;
    if ({found, f0.o_pc} !== {1'b1, 32'h100}) begin
      failures++; $display("FAIL redirect_target: got v=%b pc=%h want 1 100", found, f0.o_pc);
    end
  endtask

  task automatic test_redirect_stall_resp();
    bit hit = 1'b0;
    lat = 1;
    for (int unsigned i = 0; i < 6 && !hit; i++) begin
      begin_cycle();
      hit = f0.i_imem_valid;
      if (!hit) end_cycle(1'b0, 1'b0, '0);
    end
    end_cycle(1'b1, 1'b1, 32'h200);
    checks++;
    if ({hit, f0.o_valid} !== {1'b1, 1'b0}) begin
      failures++; $display("FAIL redir_stall_resp: got resp=%b v=%b want 1 0", hit, f0.o_valid);
    end
    cyc(1'b0, 1'b0, '0);
    checks++;
    if ({c_ren, c_raddr} !== {1'b1, 32'h200}) begin
      failures++; $display("FAIL redir_stall_ren: got %b %h want 1 200", c_ren, c_raddr);
    end
    repeat (3) cyc(1'b0, 1'b0, '0);
  endtask

  task automatic test_unaligned();
    cyc(1'b0, 1'b1, 32'h301);
    cyc(1'b0, 1'b0, '0);
    checks++;
    if ({c_ren, c_raddr} !== {1'b1, 32'h300}) begin
      failures++; $display("FAIL unaligned_raddr: got %b %h want 1 300", c_ren, c_raddr);
    end
    repeat (3) cyc(1'b0, 1'b0, '0);
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    lat = 3;
    for (int unsigned i = 0; i < 6 && !found; i++) begin
      cyc(1'b0, 1'b0, '0);
      found = c_ren;
    end
    begin_cycle();
    f0.i_stall = 1'b0; f0.i_redirect = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({found, f0.o_valid, f0.o_instr} !== {1'b1, 1'b0, NOP}) begin
      failures++; $display("FAIL async_reset: got req=%b v=%b instr=%h want 1 0 %h", found, f0.o_valid, f0.o_instr, NOP);
    end
    end_cycle(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    rst = 1'b0;
    model_reset();
    lat = 1;
    begin_cycle();
    end_cycle(1'b0, 1'b0, '0);
    checks++;
    if ({c_ren, c_raddr} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL post_reset_ren: got %b %h want 1 0", c_ren, c_raddr);
    end
    repeat (4) cyc(1'b0, 1'b0, '0);
  endtask

  task automatic test_random();
    int start = valid_seen;
    bit found = 1'b0;
    for (int unsigned i = 0; i < 1500; i++) begin
      lat = $urandom_range(1, 3);
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 24) == 0, $urandom & 32'h0000_FFFC);
    end
    for (int unsigned i = 0; i < 20 && !found; i++) begin
      cyc(1'b0, 1'b0, '0);
      found = f0.o_valid;
    end
    checks++;
    if (found !== 1'b1 || valid_seen - start < 200) begin
      failures++; $display("FAIL random_progress: got %0d instrs live=%b want >=200 and 1", valid_seen - start, found);
    end
  endtask

  task automatic test_wrap();
    rst1 = 1'b0;
    #1;
    checks++;
    if ({f1.o_imem_ren, f1.o_imem_raddr} !== {1'b1, 32'h80}) begin
      failures++; $display("FAIL wrap_first_ren: got %b %h want 1 80", f1.o_imem_ren, f1.o_imem_raddr);
    end
    f1.i_redirect = 1'b1; f1.i_redirect_pc = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (f1.o_imem_ren !== 1'b0) begin failures++; $display("FAIL wrap_redir_ren: got %b want 0", f1.o_imem_ren); end
    @(negedge clk);
    f1.i_redirect = 1'b0;
    #1;
    checks++;
    if ({f1.o_imem_ren, f1.o_imem_raddr} !== {1'b1, 32'hFFFF_FFFC}) begin
      failures++; $display("FAIL wrap_top_ren: got %b %h want 1 fffffffc", f1.o_imem_ren, f1.o_imem_raddr);
    end
    @(negedge clk);
    f1.i_imem_valid = 1'b1; f1.i_imem_rdata = instr_of(32'hFFFF_FFFC);
    #1;
    checks++;
    if ({f1.o_imem_ren, f1.o_imem_raddr} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL wrap_pc: got %b %h want 1 0", f1.o_imem_ren, f1.o_imem_raddr);
    end
    @(posedge clk); #1;
    checks++;
    if ({f1.o_valid, f1.o_pc, f1.o_pc_plus4, f1.o_instr} !== {1'b1, 32'hFFFF_FFFC, 32'h0, instr_of(32'hFFFF_FFFC)}) begin
      failures++; $display("FAIL wrap_ifid: got %b %h %h %h want 1 fffffffc 0", f1.o_valid, f1.o_pc, f1.o_pc_plus4, f1.o_instr);
    end
    @(negedge clk);
    f1.i_imem_rdata = instr_of(32'h0);
    @(posedge clk); #1;
    checks++;
    if ({f1.o_valid, f1.o_pc, f1.o_pc_plus4} !== {1'b1, 32'h0, 32'h4}) begin
      failures++; $display("FAIL wrap_next: got %b %h %h want 1 0 4", f1.o_valid, f1.o_pc, f1.o_pc_plus4);
    end
    @(negedge clk);
    f1.i_imem_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rst1 = 1'b1;
    pend = 1'b0; pend_addr = '0; cnt = 0; lat = 1; valid_seen = 0;
    c_ren = 1'b0; c_raddr = '0;
    model_reset();
    f0.i_stall = 1'b0; f0.i_redirect = 1'b0; f0.i_redirect_pc = '0;
    f0.i_imem_valid = 1'b0; f0.i_imem_rdata = '0;
    f1.i_stall = 1'b0; f1.i_redirect = 1'b0; f1.i_redirect_pc = '0;
    f1.i_imem_valid = 1'b0; f1.i_imem_rdata = '0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_redirect_wait();
    test_redirect_stall_resp();
    test_unaligned();
    test_async_reset();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
